dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the 32x8 data memory.
- Port 0 is the processor load/store path; port 1 is the loader/debug path.
- Serialises accesses with a fixed three-state sequence and round-robin fairness.
- Drives the memory's level-sensitive rd/wr/address/write-data lines from registers only, so the memory never sees glitches.

---
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 32x8 data memory.
// Each access runs IDLE -> ACCESS -> DONE, and every memory-facing line comes straight from a register.
module dmem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  // Handshake: a requester raises req with we/addr/wdata stable and holds all of
  // them until it sees its one-cycle ack. It drops req at the edge that ends the
  // ack cycle. Any req still high in IDLE counts as a new request.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e          state;
  logic            last_grant;
  logic            grant_id;
  logic            grant_sel;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  // On a tie the port that was not served last wins; otherwise the lone requester wins.
  assign grant_sel = (p0_req && p1_req) ? ~last_grant : p1_req;
  assign sel_we    = grant_sel ? p1_we    : p0_we;
  assign sel_addr  = grant_sel ? p1_addr  : p0_addr;
  assign sel_wdata = grant_sel ? p1_wdata : p0_wdata;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            grant_id  <= grant_sel;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_rd    <= ~sel_we;
            mem_wr    <= sel_we;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // mem_rdata is combinational on rd/addr, so it is settled by the closing edge.
          if (mem_rd) begin
            if (grant_id) p1_rdata <= mem_rdata;
            else          p0_rdata <= mem_rdata;
          end
          mem_rd     <= 1'b0;
          mem_wr     <= 1'b0;
          p0_ack     <= ~grant_id;
          p1_ack     <= grant_id;
          last_grant <= grant_id;
          state      <= DONE;
        end
        DONE: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural 32x8 memory, per-port expected-rdata
// queues popped on ack, and a strobe log for checking memory-side activity.
module tb_dmem_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } log_t;

  logic          clk;
  logic          rst_n;
  logic          p0_req, p0_we, p0_ack;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_ack;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          mem_rd, mem_wr, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    state_dbg;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] last_rd [2];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  log_t          mem_log [$];
  int            ack_port_q [$];
  int            ack_cyc_q [$];
  int            ack_blc_q [$];
  int            n_checks = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            busy_low_cnt = 0;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy) busy_low_cnt++;
      if (mem_rd || mem_wr) begin
        check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
        check("strobe_in_access", 32'(state_dbg), 32'd1);
        mem_log.push_back('{wr: mem_wr, addr: mem_addr, wdata: mem_wdata});
      end
      if (p0_ack) begin
        if (exp_q0.size() == 0) check("p0_unexpected_ack", 32'(p0_ack), 32'd0);
        else check("p0_rdata", 32'(p0_rdata), 32'(exp_q0.pop_front()));
        ack_port_q.push_back(0);
        ack_cyc_q.push_back(cyc);
        ack_blc_q.push_back(busy_low_cnt);
      end
      if (p1_ack) begin
        if (exp_q1.size() == 0) check("p1_unexpected_ack", 32'(p1_ack), 32'd0);
        else check("p1_rdata", 32'(p1_rdata), 32'(exp_q1.pop_front()));
        ack_port_q.push_back(1);
        ack_cyc_q.push_back(cyc);
        ack_blc_q.push_back(busy_low_cnt);
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  task automatic clear_logs();
    mem_log.delete();
    ack_port_q.delete();
    ack_cyc_q.delete();
    ack_blc_q.delete();
  endtask

  task automatic access(input int port, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    logic [DW-1:0] e;
    logic got;
    if (we) begin
      ref_mem[a] = d;
      e = last_rd[port];
    end else begin
      e = ref_mem[a];
      last_rd[port] = e;
    end
    if (port == 0) begin
      p0_we = we; p0_addr = a; p0_wdata = d; p0_req = 1'b1;
      exp_q0.push_back(e);
    end else begin
      p1_we = we; p1_addr = a; p1_wdata = d; p1_req = 1'b1;
      exp_q1.push_back(e);
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? p0_ack : p1_ack;
    end
    check((port == 0) ? "p0_ack_seen" : "p1_ack_seen", 32'(got), 32'd1);
    @(posedge clk);
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = (i < 5) ? DW'(i + 1) : '0;
      ref_mem[i] = mem[i];
    end
    p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_we = 0; p1_addr = '0; p1_wdata = '0;
    do_reset();

    // reset state
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", 32'({p0_ack, p1_ack}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rdata", 32'({p0_rdata, p1_rdata}), 32'd0);

    // p0 read of addr 3, cycle by cycle
    clear_logs();
    last_rd[0] = ref_mem[3];
    exp_q0.push_back(ref_mem[3]);
    p0_we = 0; p0_addr = 5'd3; p0_req = 1'b1;
    @(negedge clk);
    check("t1_access_state", 32'(state_dbg), 32'd1);
    check("t1_mem_rd", 32'(mem_rd), 32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'd3);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_no_early_ack", 32'(p0_ack), 32'd0);
    @(negedge clk);
    check("t1_ack", 32'(p0_ack), 32'd1);
    check("t1_rd_dropped", 32'(mem_rd), 32'd0);
    check("t1_p1_ack_low", 32'(p1_ack), 32'd0);
    check("t1_rdata", 32'(p0_rdata), 32'h04);
    @(posedge clk);
    p0_req = 1'b0;
    @(negedge clk);
    check("t1_ack_pulse", 32'(p0_ack), 32'd0);
    check("t1_idle", 32'(state_dbg), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_one_strobe", 32'(mem_log.size()), 32'd1);
    check("t1_log_is_read", 32'(mem_log[0].wr), 32'd0);

    // p1 write addr 10, then p0 reads it back
    clear_logs();
    access(1, 1'b1, 5'd10, 8'hA5);
    check("t2_one_strobe", 32'(mem_log.size()), 32'd1);
    check("t2_log_is_write", 32'(mem_log[0].wr), 32'd1);
    check("t2_log_addr", 32'(mem_log[0].addr), 32'd10);
    check("t2_log_wdata", 32'(mem_log[0].wdata), 32'hA5);
    access(0, 1'b0, 5'd10, 8'h00);
    check("t2_readback", 32'(p0_rdata), 32'hA5);

    // p0 write addr 31 (rdata must hold) then read back
    access(0, 1'b1, 5'd31, 8'hFF);
    check("t6_rdata_held", 32'(p0_rdata), 32'hA5);
    access(0, 1'b0, 5'd31, 8'h00);
    check("t6_readback", 32'(p0_rdata), 32'hFF);

    // simultaneous requests right after reset
    do_reset();
    clear_logs();
    fork
      access(0, 1'b0, 5'd0, 8'h00);
      access(1, 1'b0, 5'd1, 8'h00);
    join
    check("t3_ack_count", 32'(ack_port_q.size()), 32'd2);
    check("t3_first_p0", 32'(ack_port_q[0]), 32'd0);
    check("t3_second_p1", 32'(ack_port_q[1]), 32'd1);
    check("t3_ack_spacing", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'd3);
    check("t3_p0_rdata", 32'(p0_rdata), 32'h01);
    check("t3_p1_rdata", 32'(p1_rdata), 32'h02);

    // continuous contention, 8 transactions
    do_reset();
    clear_logs();
    fork
      for (int i = 0; i < 4; i++) access(0, 1'b0, AW'(i), 8'h00);
      for (int i = 0; i < 4; i++) access(1, 1'b0, (i % 2 == 0) ? 5'd4 : 5'd10, 8'h00);
    join
    check("t4_ack_count", 32'(ack_port_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < ack_port_q.size(); i++) begin
      check("t4_grant_order", 32'(ack_port_q[i]), 32'(i % 2));
      if (i > 0) begin
        check("t4_ack_spacing", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'd3);
        check("t4_busy_gap", 32'(ack_blc_q[i] - ack_blc_q[i-1]), 32'd1);
      end
    end

    // reset during a p1 read's ACCESS cycle
    do_reset();
    clear_logs();
    p1_we = 0; p1_addr = 5'd2; p1_req = 1'b1;
    @(negedge clk);
    check("t5_in_access", 32'(state_dbg), 32'd1);
    check("t5_mem_rd", 32'(mem_rd), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    p1_req = 1'b0;
    @(negedge clk);
    check("t5_abort_idle", 32'(state_dbg), 32'd0);
    check("t5_abort_rd", 32'(mem_rd), 32'd0);
    check("t5_abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_p1_ack", 32'(p1_ack), 32'd0);
    end
    clear_logs();
    fork
      access(0, 1'b0, 5'd4, 8'h00);
      access(1, 1'b0, 5'd3, 8'h00);
    join
    check("t5_tie_p0_first", 32'(ack_port_q[0]), 32'd0);
    access(1, 1'b0, 5'd2, 8'h00);
    check("t5_p1_served", 32'(p1_rdata), 32'h03);

    repeat (3) @(negedge clk);
    check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
